// File: rtl/pc_gen_fq.sv
// Next-fetch PC selection (priority redirects or +2/+4 stepping) with an in-flight fetch queue tagged by redirect epoch.
// Redirects reach req_pc_o in the same cycle and pc_o one cycle later; a full queue or stall_i holds issue, but a redirect is always latched.
module pc_gen_fq #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(64'h8000_0000),
    parameter int              FQ_DEPTH   = 4,
    parameter int              NUM_REDIR  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic [NUM_REDIR-1:0]      redir_valid_i,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
    input  logic                      step_half_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [XLEN-1:0]           req_pc_o,
    input  logic                      rsp_valid_i,
    output logic [XLEN-1:0]           rsp_pc_o,
    output logic                      rsp_stale_o,
    output logic [XLEN-1:0]           pc_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            epoch_q;
    logic            epoch_n;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] fq_pc [FQ_DEPTH];
    logic            fq_ep [FQ_DEPTH];

    logic            any_redir;
    logic [XLEN-1:0] redir_raw;
    logic [XLEN-1:0] redir_sel;
    logic [XLEN-1:0] step;
    logic            fire;
    logic            pop;
    logic            not_empty;

    assign any_redir = |redir_valid_i;

    // Walk from the lowest-priority channel up so channel 0 wins.
    always_comb begin
        redir_raw = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                redir_raw = redir_pc_i[k*XLEN +: XLEN];
            end
        end
    end

    assign redir_sel = redir_raw & {{(XLEN-1){1'b1}}, 1'b0};

    assign req_pc_o    = any_redir ? redir_sel : pc_q;
    assign req_valid_o = ~rst & ~stall_i & (count < CW'(FQ_DEPTH));
    assign fire        = req_valid_o & req_ready_i;
    assign epoch_n     = any_redir ? ~epoch_q : epoch_q;
    assign not_empty   = (count != '0);
    assign pop         = rsp_valid_i & not_empty;
    assign step        = step_half_i ? XLEN'(2) : XLEN'(4);

    always_comb begin
        pc_d = pc_q;
        if (fire) begin
            pc_d = req_pc_o + step;
        end else if (any_redir) begin
            pc_d = redir_sel;
        end
        pc_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            epoch_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_n;
            if (fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (fire) begin
            fq_pc[wr_ptr] <= req_pc_o;
            fq_ep[wr_ptr] <= epoch_n;
        end
    end

    assign rsp_pc_o    = not_empty ? fq_pc[rd_ptr] : '0;
    assign rsp_stale_o = ~rst & not_empty & ((fq_ep[rd_ptr] != epoch_q) | any_redir);
    assign pc_o        = pc_q;
    assign fq_count_o  = count;

endmodule

// File: tb/tb_pc_gen_fq.sv
// Directed bench for pc_gen_fq: expected fetch PCs and responses are queued by the stimulus and consumed by a negedge monitor.
module tb_pc_gen_fq;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic        stale;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall_i;
    logic [2:0]   redir_valid_i;
    logic [191:0] redir_pc_i;
    logic         step_half_i;
    logic         req_valid_o;
    logic         req_ready_i;
    logic [63:0]  req_pc_o;
    logic         rsp_valid_i;
    logic [63:0]  rsp_pc_o;
    logic         rsp_stale_o;
    logic [63:0]  pc_o;
    logic [2:0]   fq_count_o;

    logic [63:0] exp_req_q [$];
    rsp_t        exp_rsp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pc_gen_fq dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .step_half_i   (step_half_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_pc_o      (req_pc_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_pc_o      (rsp_pc_o),
        .rsp_stale_o   (rsp_stale_o),
        .pc_o          (pc_o),
        .fq_count_o    (fq_count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        rsp_valid_i = 1'b1;
        repeat (n) tick();
        rsp_valid_i = 1'b0;
    endtask

    // Fires and pops are judged mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (req_valid_o && req_ready_i) begin
            if (exp_req_q.size() == 0) begin
                chk("req_unexpected", req_pc_o, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                chk("req_pc", req_pc_o, exp_req_q.pop_front());
            end
        end
        if (rsp_valid_i && fq_count_o != 3'd0) begin
            rsp_t e;
            if (exp_rsp_q.size() == 0) begin
                chk("rsp_unexpected", rsp_pc_o, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = exp_rsp_q.pop_front();
                chk("rsp_pc", rsp_pc_o, e.pc);
                chk("rsp_stale", {63'd0, rsp_stale_o}, {63'd0, e.stale});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; redir_valid_i = '0; redir_pc_i = '0;
        step_half_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
        tick(); tick();
        chk("rst_valid", {63'd0, req_valid_o}, 64'd0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_count", {61'd0, fq_count_o}, 64'd0);
        chk("rst_stale", {63'd0, rsp_stale_o}, 64'd0);
        rst = 1'b0;
        #1;
        chk("first_valid", {63'd0, req_valid_o}, 64'd1);
        chk("first_pc", req_pc_o, RST_PC);

        // Sequential +4 stepping
        exp_req_q.push_back(64'h8000_0000);
        exp_req_q.push_back(64'h8000_0004);
        exp_req_q.push_back(64'h8000_0008);
        req_ready_i = 1'b1;
        repeat (3) tick();
        req_ready_i = 1'b0;
        chk("seq_count", {61'd0, fq_count_o}, 64'd3);
        chk("seq_pc", pc_o, 64'h8000_000C);
        exp_rsp_q.push_back('{64'h8000_0000, 1'b0});
        exp_rsp_q.push_back('{64'h8000_0004, 1'b0});
        exp_rsp_q.push_back('{64'h8000_0008, 1'b0});
        drain(3);
        chk("seq_drained", {61'd0, fq_count_o}, 64'd0);
        chk("empty_rsp_pc", rsp_pc_o, 64'd0);

        // Mixed +4 / +2 stepping after a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        exp_req_q.push_back(64'h8000_0000);
        exp_req_q.push_back(64'h8000_0004);
        exp_req_q.push_back(64'h8000_0006);
        req_ready_i = 1'b1;
        tick(); step_half_i = 1'b1;
        tick(); step_half_i = 1'b0;
        tick(); req_ready_i = 1'b0;
        chk("half_pc", pc_o, 64'h8000_000A);
        exp_rsp_q.push_back('{64'h8000_0000, 1'b0});
        exp_rsp_q.push_back('{64'h8000_0004, 1'b0});
        exp_rsp_q.push_back('{64'h8000_0006, 1'b0});
        drain(3);

        // Redirect while stalled: channel 0 outranks channel 2
        stall_i = 1'b1; req_ready_i = 1'b1;
        redir_valid_i = 3'b101;
        redir_pc_i[0 +: 64]   = 64'h2000;
        redir_pc_i[128 +: 64] = 64'h1000;
        #1;
        chk("stall_valid", {63'd0, req_valid_o}, 64'd0);
        chk("redir_bypass", req_pc_o, 64'h2000);
        tick();
        redir_valid_i = '0;
        #1;
        chk("redir_pc", pc_o, 64'h2000);
        exp_req_q.push_back(64'h2000);
        stall_i = 1'b0;
        tick(); req_ready_i = 1'b0;
        chk("post_redir_count", {61'd0, fq_count_o}, 64'd1);
        chk("post_redir_pc", pc_o, 64'h2004);
        exp_rsp_q.push_back('{64'h2000, 1'b0});
        drain(1);

        // Fill to capacity; full blocks issue even with a response present
        for (int i = 0; i < 4; i++) exp_req_q.push_back(64'h2004 + 64'(4 * i));
        req_ready_i = 1'b1;
        repeat (6) tick();
        chk("full_valid", {63'd0, req_valid_o}, 64'd0);
        chk("full_count", {61'd0, fq_count_o}, 64'd4);
        chk("full_pc", pc_o, 64'h2014);
        exp_rsp_q.push_back('{64'h2004, 1'b0});
        rsp_valid_i = 1'b1;
        #1;
        chk("full_no_bypass", {63'd0, req_valid_o}, 64'd0);
        tick();
        rsp_valid_i = 1'b0;
        exp_req_q.push_back(64'h2014);
        #1;
        chk("after_pop_count", {61'd0, fq_count_o}, 64'd3);
        chk("after_pop_valid", {63'd0, req_valid_o}, 64'd1);
        tick();
        req_ready_i = 1'b0;
        chk("refill_count", {61'd0, fq_count_o}, 64'd4);
        exp_rsp_q.push_back('{64'h2008, 1'b0});
        exp_rsp_q.push_back('{64'h200C, 1'b0});
        exp_rsp_q.push_back('{64'h2010, 1'b0});
        exp_rsp_q.push_back('{64'h2014, 1'b0});
        drain(4);

        // Stale tagging around a redirect (target bit 0 must be cleared)
        exp_req_q.push_back(64'h2018);
        exp_req_q.push_back(64'h201C);
        req_ready_i = 1'b1;
        repeat (2) tick();
        redir_valid_i = 3'b010;
        redir_pc_i[64 +: 64] = 64'h3001;
        exp_req_q.push_back(64'h3000);
        exp_rsp_q.push_back('{64'h2018, 1'b1});
        rsp_valid_i = 1'b1;
        #1;
        chk("redir_mask", req_pc_o, 64'h3000);
        tick();
        redir_valid_i = '0; req_ready_i = 1'b0;
        exp_rsp_q.push_back('{64'h201C, 1'b1});
        exp_rsp_q.push_back('{64'h3000, 1'b0});
        repeat (2) tick();
        rsp_valid_i = 1'b0;
        chk("stale_drained", {61'd0, fq_count_o}, 64'd0);
        chk("stale_pc", pc_o, 64'h3004);

        // PC wraps modulo 2^64
        redir_valid_i = 3'b001;
        redir_pc_i[0 +: 64] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        req_ready_i = 1'b1;
        tick();
        redir_valid_i = '0; req_ready_i = 1'b0;
        chk("wrap_pc", pc_o, 64'd0);
        exp_rsp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
        drain(1);

        // Reset with requests outstanding
        exp_req_q.push_back(64'h0);
        exp_req_q.push_back(64'h4);
        exp_req_q.push_back(64'h8);
        req_ready_i = 1'b1;
        repeat (3) tick();
        chk("pre_rst_count", {61'd0, fq_count_o}, 64'd3);
        rst = 1'b1;
        tick();
        chk("mid_rst_count", {61'd0, fq_count_o}, 64'd0);
        chk("mid_rst_pc", pc_o, RST_PC);
        chk("mid_rst_valid", {63'd0, req_valid_o}, 64'd0);
        chk("mid_rst_stale", {63'd0, rsp_stale_o}, 64'd0);
        rst = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b1;
        tick();
        rsp_valid_i = 1'b0;
        chk("ignored_rsp_count", {61'd0, fq_count_o}, 64'd0);
        chk("ignored_rsp_pc", rsp_pc_o, 64'd0);
        exp_req_q.push_back(RST_PC);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        chk("restart_count", {61'd0, fq_count_o}, 64'd1);
        exp_rsp_q.push_back('{RST_PC, 1'b0});
        drain(1);

        chk("req_queue_left", 64'(exp_req_q.size()), 64'd0);
        chk("rsp_queue_left", 64'(exp_rsp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen_fq.md
# pc_gen_fq

Parametrised program-counter generator with an in-flight fetch queue, the successor to the single-register PC stage. It sits in front of the icache and selects the next fetch PC from N priority-ordered redirect channels or from sequential +2/+4 stepping. It issues fetches over a valid/ready handshake and tracks up to FQ_DEPTH outstanding requests in a FIFO. Each request is tagged with a redirect epoch so that responses to fetches issued before a redirect are flagged stale.

## Interface
- XLEN, 64, PC width
- RESET_ADDR, 64'h8000_0000, PC value after reset
- FQ_DEPTH, 4, outstanding-fetch capacity; power of 2, ≥2
- NUM_REDIR, 3, redirect channels; index 0 has the highest priority (trap > branch > bpu)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  holds issue; PC is held unless a redirect arrives
- redir_valid_i  in  NUM_REDIR  per-channel redirect request
- redir_pc_i  in  NUM_REDIR*XLEN  redirect targets; channel k occupies bits [k*XLEN +: XLEN]
- step_half_i  in  1  1 selects a +2 step (compressed instruction), 0 selects +4
- req_valid_o  out  1  fetch request valid
- req_ready_i  in  1  icache accepts the request
- req_pc_o  out  XLEN  fetch address
- rsp_valid_i  in  1  icache returns data for the oldest outstanding request
- rsp_pc_o  out  XLEN  PC of the queue head
- rsp_stale_o  out  1  head belongs to an older epoch; the response must be discarded
- pc_o  out  XLEN  registered current PC (pc_q)
- fq_count_o  out  $clog2(FQ_DEPTH)+1  number of outstanding requests

## Operation
- State:
  - pc_q, reset value RESET_ADDR
  - epoch_q, 1 bit, reset value 0
  - FIFO of {pc, epoch}, with wr_ptr, rd_ptr and count, all reset to 0
- Redirect select:
  - any_redir = |redir_valid_i.
  - redir_sel is the target of the lowest-index asserted channel.
  - Bit 0 of every PC written to pc_q or issued is forced to 0.
- Fetch address: req_pc_o = any_redir ? redir_sel : pc_q. This is a combinational bypass, so a redirect is fetched in the same cycle.
- Request valid: req_valid_o = ~rst & ~stall_i & (count < FQ_DEPTH).
  - There is no pop-bypass: a full queue blocks issue even if rsp_valid_i is high.
- Fire: fire = req_valid_o & req_ready_i.
  - Push {req_pc_o, epoch_n} into the FIFO, where epoch_n = any_redir ? ~epoch_q : epoch_q.
  - pc_q ← req_pc_o + (step_half_i ? 2 : 4), computed modulo 2^XLEN (wraps silently).
- No fire with any_redir: pc_q ← redir_sel. The redirect is never lost, even while stalled, full or not ready.
- No fire and no redirect: pc_q holds.
- epoch_q ← epoch_n every cycle, so it toggles exactly once per redirect cycle.
- Pop: when rsp_valid_i and count > 0, rd_ptr advances.
  - rsp_valid_i with an empty queue is ignored; nothing is popped.
- Head outputs:
  - rsp_pc_o is the head pc; it is 0 when the queue is empty.
  - rsp_stale_o = (count > 0) & ((head.epoch != epoch_q) | any_redir). A response coinciding with a redirect is always stale.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo FQ_DEPTH.

## Timing
- Redirect to req_pc_o: 0 cycles (combinational).
- Redirect to pc_o: 1 cycle.
- A fire in cycle t gives fq_count_o +1 and the advanced pc_o at t+1.
- A pop in cycle t gives fq_count_o −1 at t+1.
- With rst high at a clock edge, all state returns to reset values on that edge, including mid-burst or with a full queue. While rst is high:
  - req_valid_o = 0
  - pc_o = RESET_ADDR after the first edge
  - fq_count_o = 0
  - rsp_stale_o = 0
- The first request, RESET_ADDR, is offered the cycle after rst falls (given stall_i = 0).
- Throughput: one request per cycle while ready and not full.

## Test plan
- Reset, then req_ready_i = 1 for 3 cycles with step_half_i = 0 -> req_pc_o issues 0x80000000, 0x80000004, 0x80000008; fq_count_o = 3.
- step_half_i = 1 on the second fire -> sequence 0x80000000, 0x80000004, 0x80000006.
- Channels 2 and 0 both valid (targets 0x1000 and 0x2000) while stall_i = 1 -> pc_o = 0x2000 next cycle, no fire, epoch toggles; after unstall the first request is 0x2000.
- req_ready_i = 1 with rsp_valid_i = 0 for FQ_DEPTH+2 cycles -> req_valid_o drops after 4 fires and fq_count_o = 4; a single rsp_valid_i pulse -> count 3, then one more fire.
- Issue 2 fetches, redirect to 0x3000, return 3 responses -> first two have rsp_stale_o = 1, the third (0x3000) has rsp_stale_o = 0; a response in the redirect cycle itself is stale.
- Assert rst with 3 outstanding requests -> fq_count_o = 0, pc_o = 0x80000000, a following rsp_valid_i is ignored, and issue restarts at 0x80000000.
